// File: rtl/ram_tp_arb.sv
// ram_tp_arb: round-robin arbiter sharing one two-port RAM (one write port, one read
// port) between N_REQ requesters. Write and read arbitration are independent. Read
// responses return to the issuing requester 1+RD_LAT cycles after the handshake.
// Optional build macro RAM_TP_ARB_RAW_STALL_EN: a read whose address matches the write
// handshaking in the same cycle is held off one cycle, so it observes the new data.
module ram_tp_arb #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [N_REQ-1:0]              wr_valid_i,
  output logic [N_REQ-1:0]              wr_ready_o,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   wr_addr_i,
  input  logic [N_REQ*DATA_WIDTH-1:0]   wr_data_i,
  input  logic [N_REQ-1:0]              rd_valid_i,
  output logic [N_REQ-1:0]              rd_ready_o,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   rd_addr_i,
  output logic [N_REQ-1:0]              rsp_valid_o,
  output logic [DATA_WIDTH-1:0]         rsp_data_o,
  output logic                          ram_wr_en_o,
  output logic [ADDR_WIDTH-1:0]         ram_wr_addr_o,
  output logic [DATA_WIDTH-1:0]         ram_wr_data_o,
  output logic                          ram_rd_en_o,
  output logic [ADDR_WIDTH-1:0]         ram_rd_addr_o,
  input  logic [DATA_WIDTH-1:0]         ram_rd_data_i
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // Response tag pipeline flattened: stage s occupies bits [s*N_REQ +: N_REQ].
  localparam int unsigned TW = (RD_LAT + 1) * N_REQ;

  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [PW-1:0]         wr_idx, rd_idx;
  logic                  wr_found, rd_found;
  logic                  wr_hs, rd_hs, raw_hit;
  logic [ADDR_WIDTH-1:0] wr_addr_sel, rd_addr_sel;
  logic [DATA_WIDTH-1:0] wr_data_sel;
  logic [N_REQ-1:0]      rd_tag;
  logic [TW-1:0]         tag_q;
  logic [DATA_WIDTH-1:0] rsp_hold_q;

  // First requester with valid set, searching upward from ptr with wrap; {found, idx}.
  function automatic logic [PW:0] rr_pick(input logic [N_REQ-1:0] req,
                                          input logic [PW-1:0] ptr);
    logic          found;
    logic [PW-1:0] idx;
    int unsigned   k;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      k = (32'(ptr) + i) % N_REQ;
      if (!found && req[k[PW-1:0]]) begin
        found = 1'b1;
        idx   = k[PW-1:0];
      end
    end
    return {found, idx};
  endfunction

  // Next pointer value: one past the granted requester, wrapping to 0.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] g);
    return (32'(g) == N_REQ - 1) ? '0 : g + PW'(1);
  endfunction

  // Combinational arbitration for both ports.
  always_comb begin
    {wr_found, wr_idx} = rr_pick(wr_valid_i, wr_ptr_q);
    {rd_found, rd_idx} = rr_pick(rd_valid_i, rd_ptr_q);
  end

  assign wr_addr_sel = wr_addr_i[32'(wr_idx) * ADDR_WIDTH +: ADDR_WIDTH];
  assign wr_data_sel = wr_data_i[32'(wr_idx) * DATA_WIDTH +: DATA_WIDTH];
  assign rd_addr_sel = rd_addr_i[32'(rd_idx) * ADDR_WIDTH +: ADDR_WIDTH];
  assign wr_hs       = wr_found;

`ifdef RAM_TP_ARB_RAW_STALL_EN
  assign raw_hit = wr_hs && rd_found && (rd_addr_sel == wr_addr_sel);
`else
  assign raw_hit = 1'b0;
`endif

  assign rd_hs      = rd_found && !raw_hit;
  assign wr_ready_o = wr_hs ? (N_REQ'(1) << wr_idx) : '0;
  assign rd_tag     = rd_hs ? (N_REQ'(1) << rd_idx) : '0;
  assign rd_ready_o = rd_tag;

  // Round-robin pointers advance past the winner only on a handshake.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_hs) wr_ptr_q <= ptr_next(wr_idx);
      if (rd_hs) rd_ptr_q <= ptr_next(rd_idx);
    end
  end

  // Issue stage: strobe the RAM for one cycle; addr/data hold between accesses.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ram_wr_en_o   <= 1'b0;
      ram_wr_addr_o <= '0;
      ram_wr_data_o <= '0;
      ram_rd_en_o   <= 1'b0;
      ram_rd_addr_o <= '0;
    end else begin
      ram_wr_en_o <= wr_hs;
      ram_rd_en_o <= rd_hs;
      if (wr_hs) begin
        ram_wr_addr_o <= wr_addr_sel;
        ram_wr_data_o <= wr_data_sel;
      end
      if (rd_hs) ram_rd_addr_o <= rd_addr_sel;
    end
  end

  // Tag shift pipeline: stage 0 lines up with ram_rd_en_o, last stage with RAM data.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tag_q <= '0;
    end else begin
      tag_q <= TW'({tag_q, rd_tag});
    end
  end

  assign rsp_valid_o = tag_q[RD_LAT * N_REQ +: N_REQ];

  // Keep the last returned word so rsp_data_o is stable between responses.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rsp_hold_q <= '0;
    end else if (|rsp_valid_o) begin
      rsp_hold_q <= ram_rd_data_i;
    end
  end

  assign rsp_data_o = (|rsp_valid_o) ? ram_rd_data_i : rsp_hold_q;

endmodule

// File: tb/tb_ram_tp_arb.sv
// Self-checking bench for ram_tp_arb: an RD_LAT=1 and an RD_LAT=0 instance share the
// same requester stimulus, each with its own behavioural RAM. Expectations come from a
// transaction-level model (integer pointers, array memory, queue of due responses).
module tb_ram_tp_arb;
  localparam int N  = 4;
  localparam int AW = 6;
  localparam int DW = 32;

  logic clk, rst_n;
  logic [N-1:0]    wr_valid, rd_valid;
  logic [N*AW-1:0] wr_addr, rd_addr;
  logic [N*DW-1:0] wr_data;

  logic [N-1:0]  wr_ready1, rd_ready1, rsp_valid1, wr_ready0, rd_ready0, rsp_valid0;
  logic [DW-1:0] rsp_data1, rsp_data0, ram_wr_data1, ram_wr_data0, rd_q1, rd_data0;
  logic [AW-1:0] ram_wr_addr1, ram_rd_addr1, ram_wr_addr0, ram_rd_addr0;
  logic          ram_wr_en1, ram_rd_en1, ram_wr_en0, ram_rd_en0;

  ram_tp_arb #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(1)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready1), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_valid_i(rd_valid), .rd_ready_o(rd_ready1), .rd_addr_i(rd_addr),
    .rsp_valid_o(rsp_valid1), .rsp_data_o(rsp_data1),
    .ram_wr_en_o(ram_wr_en1), .ram_wr_addr_o(ram_wr_addr1), .ram_wr_data_o(ram_wr_data1),
    .ram_rd_en_o(ram_rd_en1), .ram_rd_addr_o(ram_rd_addr1), .ram_rd_data_i(rd_q1)
  );

  ram_tp_arb #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(0)) u_dut0 (
    .clk_i(clk), .rst_n_i(rst_n),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready0), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_valid_i(rd_valid), .rd_ready_o(rd_ready0), .rd_addr_i(rd_addr),
    .rsp_valid_o(rsp_valid0), .rsp_data_o(rsp_data0),
    .ram_wr_en_o(ram_wr_en0), .ram_wr_addr_o(ram_wr_addr0), .ram_wr_data_o(ram_wr_data0),
    .ram_rd_en_o(ram_rd_en0), .ram_rd_addr_o(ram_rd_addr0), .ram_rd_data_i(rd_data0)
  );

  // Behavioural RAMs: registered read (read-before-write) and combinational read.
  logic [DW-1:0] mem1 [0:63];
  logic [DW-1:0] mem0 [0:63];
  always @(posedge clk) begin
    if (ram_rd_en1) rd_q1 <= mem1[ram_rd_addr1];
    if (ram_wr_en1) mem1[ram_wr_addr1] <= ram_wr_data1;
    if (ram_wr_en0) mem0[ram_wr_addr0] <= ram_wr_data0;
  end
  assign rd_data0 = mem0[ram_rd_addr0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {int due; int req; logic [DW-1:0] data;} rsp_t;
  rsp_t          pend1[$], pend0[$];
  logic [DW-1:0] mdl_mem [0:63];
  int            wptr, rptr, cyc;
  logic [DW-1:0] ld1, ld0, e_wr_data;
  logic [AW-1:0] e_wr_addr, e_rd_addr;
  logic          e_wr_en, e_rd_en;
  int            n_cmp, n_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int i = 0; i < N; i++) if (v[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  task automatic model_clear();
    pend1.delete(); pend0.delete();
    wptr = 0; rptr = 0; ld1 = '0; ld0 = '0;
    e_wr_en = 1'b0; e_rd_en = 1'b0; e_wr_addr = '0; e_rd_addr = '0; e_wr_data = '0;
  endtask

  // One cycle: check registered outputs and grants, advance the model, clock once.
  task automatic step();
    int wg, rg;
    logic [N-1:0] ew, er, ev1, ev0;
    logic [AW-1:0] a;
    #1;
    ev1 = '0;
    if (pend1.size() > 0 && pend1[0].due == cyc) begin
      ev1 = 4'(1) << pend1[0].req; ld1 = pend1[0].data; void'(pend1.pop_front());
    end
    ev0 = '0;
    if (pend0.size() > 0 && pend0[0].due == cyc) begin
      ev0 = 4'(1) << pend0[0].req; ld0 = pend0[0].data; void'(pend0.pop_front());
    end
    chk("rsp_valid", 64'(rsp_valid1), 64'(ev1));
    chk("rsp_data", 64'(rsp_data1), 64'(ld1));
    chk("rsp_valid_lat0", 64'(rsp_valid0), 64'(ev0));
    chk("rsp_data_lat0", 64'(rsp_data0), 64'(ld0));
    chk("ram_wr_en", 64'(ram_wr_en1), 64'(e_wr_en));
    chk("ram_wr_addr", 64'(ram_wr_addr1), 64'(e_wr_addr));
    chk("ram_wr_data", 64'(ram_wr_data1), 64'(e_wr_data));
    chk("ram_rd_en", 64'(ram_rd_en1), 64'(e_rd_en));
    chk("ram_rd_addr", 64'(ram_rd_addr1), 64'(e_rd_addr));
    wg = pick(wr_valid, wptr);
    rg = pick(rd_valid, rptr);
`ifdef RAM_TP_ARB_RAW_STALL_EN
    if (wg >= 0 && rg >= 0 && wr_addr[wg*AW +: AW] == rd_addr[rg*AW +: AW]) rg = -1;
`endif
    ew = (wg >= 0) ? 4'(1) << wg : '0;
    er = (rg >= 0) ? 4'(1) << rg : '0;
    chk("wr_ready", 64'(wr_ready1), 64'(ew));
    chk("rd_ready", 64'(rd_ready1), 64'(er));
    chk("wr_ready_lat0", 64'(wr_ready0), 64'(ew));
    chk("rd_ready_lat0", 64'(rd_ready0), 64'(er));
    e_rd_en = (rg >= 0);
    if (rg >= 0) begin
      a = rd_addr[rg*AW +: AW];
      pend1.push_back('{cyc + 2, rg, mdl_mem[a]});
      pend0.push_back('{cyc + 1, rg, mdl_mem[a]});
      rptr = (rg + 1) % N;
      e_rd_addr = a;
    end
    e_wr_en = (wg >= 0);
    if (wg >= 0) begin
      a = wr_addr[wg*AW +: AW];
      mdl_mem[a] = wr_data[wg*DW +: DW];
      wptr = (wg + 1) % N;
      e_wr_addr = a;
      e_wr_data = wr_data[wg*DW +: DW];
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle();
    wr_valid = '0; rd_valid = '0;
  endtask

  task automatic set_wr(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_valid[k] = 1'b1; wr_addr[k*AW +: AW] = a; wr_data[k*DW +: DW] = d;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    rd_valid[k] = 1'b1; rd_addr[k*AW +: AW] = a;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ram_wr_en"}, 64'(ram_wr_en1), 64'(0));
    chk({tag, "_ram_wr_addr"}, 64'(ram_wr_addr1), 64'(0));
    chk({tag, "_ram_wr_data"}, 64'(ram_wr_data1), 64'(0));
    chk({tag, "_ram_rd_en"}, 64'(ram_rd_en1), 64'(0));
    chk({tag, "_ram_rd_addr"}, 64'(ram_rd_addr1), 64'(0));
    chk({tag, "_rsp_valid"}, 64'(rsp_valid1), 64'(0));
    chk({tag, "_rsp_data"}, 64'(rsp_data1), 64'(0));
    chk({tag, "_rsp_valid_lat0"}, 64'(rsp_valid0), 64'(0));
    chk({tag, "_rsp_data_lat0"}, 64'(rsp_data0), 64'(0));
  endtask

  logic [N-1:0]  exp_rr [5];
  logic [DW-1:0] raw_exp;
  logic          found;

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0;
    for (int i = 0; i < 64; i++) begin
      mem1[i] = '0; mem0[i] = '0; mdl_mem[i] = '0;
    end
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    idle();
    model_clear();
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // All readers valid: strict rotation from requester 0.
    exp_rr[0] = 4'b0001; exp_rr[1] = 4'b0010; exp_rr[2] = 4'b0100;
    exp_rr[3] = 4'b1000; exp_rr[4] = 4'b0001;
    for (int k = 0; k < N; k++) set_rd(k, AW'(10 + k));
    for (int i = 0; i < 5; i++) begin
      #1 chk("rr_seq", 64'(rd_ready1), 64'(exp_rr[i]));
      step();
    end
    idle();
    repeat (3) step();

    // Write then read back two cycles later.
    set_wr(2, 6'd5, 32'hA5A5A5A5);
    step();
    idle();
    step();
    set_rd(0, 6'd5);
    step();
    idle();
    step();
    #1;
    chk("wr_rd_rsp_valid", 64'(rsp_valid1), 64'(4'b0001));
    chk("wr_rd_rsp_data", 64'(rsp_data1), 64'(32'hA5A5A5A5));
    step();

    // Same-cycle write and read to address 3 (old value 0).
    set_wr(1, 6'd3, 32'h11);
    set_rd(3, 6'd3);
`ifdef RAM_TP_ARB_RAW_STALL_EN
    raw_exp = 32'h11;
    #1 chk("raw_rd_ready", 64'(rd_ready1), 64'(4'b0000));
    step();
    wr_valid = '0;
    step();
    rd_valid = '0;
`else
    raw_exp = 32'h00;
    #1 chk("raw_rd_ready", 64'(rd_ready1), 64'(4'b1000));
    step();
    idle();
`endif
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      #1;
      if (rsp_valid1 == 4'b1000) found = 1'b1;
      else step();
    end
    chk("raw_rsp_seen", 64'(found), 64'(1));
    chk("raw_rsp_data", 64'(rsp_data1), 64'(raw_exp));
    step();

    // Reset one cycle after a read handshake drops the response.
    set_rd(2, 6'd7);
    step();
    idle();
    #1 rst_n = 1'b0;
    #1 chk_zero("mid_reset");
    model_clear();
    @(posedge clk); @(posedge clk);
    #1 chk_zero("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();

    // Only requester 3 valid with pointer at 0; pointer then wraps to 0.
    set_wr(3, 6'd20, 32'hCAFE0003);
    #1 chk("wrap_grant3", 64'(wr_ready1), 64'(4'b1000));
    step();
    set_wr(0, 6'd21, 32'hCAFE0000);
    #1 chk("wrap_then0", 64'(wr_ready1), 64'(4'b0001));
    step();
    idle();
    step();

    // Randomised traffic on a small address range to force collisions.
    for (int i = 0; i < 400; i++) begin
      wr_valid = 4'($urandom);
      rd_valid = 4'($urandom);
      for (int k = 0; k < N; k++) begin
        wr_addr[k*AW +: AW] = AW'($urandom_range(0, 7));
        rd_addr[k*AW +: AW] = AW'($urandom_range(0, 7));
        wr_data[k*DW +: DW] = $urandom;
      end
      step();
    end
    idle();
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
